// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through an external PC register,
// issues one instruction-memory request at a time and hands words to decode.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_INC       = 16'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] PC_OUT,
  output logic [15:0] PC_IN,
  output logic        C_PCWrite,
  input  logic        C_Enable,
  input  logic        C_Redirect,
  input  logic [15:0] REDIRECT_ADDR,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [15:0] IMEM_DATA,
  output logic [15:0] INSTR,
  output logic [15:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4,
    S_VALID = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] addr_q;
  logic [15:0] instr_q;
  logic [15:0] instr_pc_q;
  logic        xfer;
  state_t      resume;

  // Decode handshake: a word moves when INSTR_VALID and INSTR_READY are both
  // high at a rising edge; INSTR/INSTR_PC hold steady until that edge.
  assign xfer   = INSTR_VALID && INSTR_READY;
  assign resume = C_Enable ? S_REQ : S_IDLE;

  assign IMEM_REQ    = (state == S_REQ);
  assign IMEM_ADDR   = (state == S_REQ) ? PC_OUT : addr_q;
  assign INSTR_VALID = (state == S_VALID);
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign dbg_state   = state;

  // PC update is same-cycle: redirect beats the sequential increment.
  always_comb begin
    PC_IN     = PC_OUT;
    C_PCWrite = 1'b0;
    if (state == S_BOOT) begin
      PC_IN     = RESET_VECTOR;
      C_PCWrite = 1'b1;
    end else if (C_Redirect) begin
      PC_IN     = REDIRECT_ADDR;
      C_PCWrite = 1'b1;
    end else if (state == S_WAIT && IMEM_ACK) begin
      PC_IN     = PC_OUT + PC_INC;
      C_PCWrite = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_BOOT;
      addr_q     <= 16'h0000;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
    end else begin
      case (state)
        S_BOOT: state <= S_IDLE;
        S_IDLE: begin
          if (C_Enable) state <= S_REQ;
        end
        S_REQ: begin
          addr_q <= PC_OUT;
          state  <= C_Redirect ? S_FLUSH : S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_ACK) begin
            if (C_Redirect) begin
              state <= resume;
            end else begin
              instr_q    <= IMEM_DATA;
              instr_pc_q <= addr_q;
              state      <= S_VALID;
            end
          end else if (C_Redirect) begin
            state <= S_FLUSH;
          end
        end
        // The ack retires the abandoned request, so it wins over a redirect.
        S_FLUSH: begin
          if (IMEM_ACK) state <= resume;
        end
        S_VALID: begin
          if (C_Redirect || xfer) state <= resume;
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models the external PC register and a
// variable-latency instruction memory, and scoreboards delivered words.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc_out;
  logic [15:0] PC_IN;
  logic        C_PCWrite;
  logic        C_Enable;
  logic        C_Redirect;
  logic [15:0] REDIRECT_ADDR;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic [15:0] INSTR;
  logic [15:0] INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  fetch_sequencer #(.RESET_VECTOR(16'h0000), .PC_INC(16'd1)) dut (
    .clk(clk), .reset_n(reset_n), .PC_OUT(pc_out), .PC_IN(PC_IN),
    .C_PCWrite(C_PCWrite), .C_Enable(C_Enable), .C_Redirect(C_Redirect),
    .REDIRECT_ADDR(REDIRECT_ADDR), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .INSTR(INSTR),
    .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .dbg_state(dbg_state)
  );

  // Clock, external PC register and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (C_PCWrite) pc_out <= PC_IN;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the oldest expected {pc, data}
  always @(negedge clk) begin
    if (reset_n === 1'b1 && INSTR_VALID === 1'b1 && INSTR_READY === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("transfer", {INSTR_PC, INSTR}, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en);
    reset_n = 1'b0;
    C_Enable = en; C_Redirect = 1'b0; REDIRECT_ADDR = 16'h0000;
    IMEM_ACK = 1'b0; IMEM_DATA = 16'h0000; INSTR_READY = 1'b1;
    exp_q.delete();
    step(); step(); step();
    reset_n = 1'b1;
  endtask

  task automatic wait_req(output int at_cyc);
    int n = 0;
    while (IMEM_REQ !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, IMEM_REQ}, 32'd1);
    at_cyc = cyc;
  endtask

  // Memory driver: answers the next request lat cycles after it issues
  task automatic fetch_one(input int lat, input logic [15:0] exp_addr,
                           input logic [15:0] data, output int at_cyc);
    logic [15:0] nxt;
    wait_req(at_cyc);
    check("imem_addr", {16'd0, IMEM_ADDR}, {16'd0, exp_addr});
    for (int i = 0; i < lat; i++) begin
      step();
      if (i == 0) check("req_one_cycle", {31'd0, IMEM_REQ}, 32'd0);
    end
    IMEM_ACK = 1'b1; IMEM_DATA = data;
    #1;
    nxt = exp_addr + 16'd1;
    check("pc_next", {16'd0, PC_IN}, {16'd0, nxt});
    check("pc_write_ack", {31'd0, C_PCWrite}, 32'd1);
    exp_q.push_back({exp_addr, data});
    step();
    IMEM_ACK = 1'b0; IMEM_DATA = 16'h0000;
  endtask

  initial begin
    int c0, c1;
    // Reset values while reset_n is low
    do_reset(1'b0);
    reset_n = 1'b0;
    #1;
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    check("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("rst_instr", {INSTR_PC, INSTR}, 32'd0);
    check("rst_pc_in", {16'd0, PC_IN}, 32'd0);
    check("rst_pc_write", {31'd0, C_PCWrite}, 32'd1);

    // Sequential fetch 0,1,2,3 with 1-cycle memory, requests 3 cycles apart
    do_reset(1'b1);
    fetch_one(1, 16'h0000, 16'h1000, c0);
    for (int i = 1; i < 4; i++) begin
      fetch_one(1, 16'(i), 16'h1000 + 16'(i * 16'h0111), c1);
      check("req_spacing", c1 - c0, 32'd3);
      c0 = c1;
    end
    step();
    check("pc_after_seq", {16'd0, pc_out}, 32'd4);

    // Slow memory and a stalled decode: word held, no new request
    do_reset(1'b1);
    INSTR_READY = 1'b0;
    fetch_one(4, 16'h0000, 16'hBEEF, c0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
      check("hold_instr", {INSTR_PC, INSTR}, {16'h0000, 16'hBEEF});
      check("hold_no_req", {31'd0, IMEM_REQ}, 32'd0);
      step();
    end
    INSTR_READY = 1'b1;
    step();
    check("req_after_xfer", {15'd0, IMEM_REQ, IMEM_ADDR}, {15'd0, 1'b1, 16'h0001});

    // Redirect while waiting: stale data dropped, refetch at the target
    do_reset(1'b1);
    wait_req(c0);
    step();
    C_Redirect = 1'b1; REDIRECT_ADDR = 16'h0040;
    #1;
    check("redir_wait_pc", {15'd0, C_PCWrite, PC_IN}, {15'd0, 1'b1, 16'h0040});
    step();
    C_Redirect = 1'b0;
    step();
    IMEM_ACK = 1'b1; IMEM_DATA = 16'hDEAD;
    #1;
    check("flush_no_write", {31'd0, C_PCWrite}, 32'd0);
    step();
    IMEM_ACK = 1'b0;
    fetch_one(1, 16'h0040, 16'h4040, c0);

    // Redirect in the same cycle as the ack
    do_reset(1'b1);
    wait_req(c0);
    step();
    IMEM_ACK = 1'b1; IMEM_DATA = 16'hDEAD;
    C_Redirect = 1'b1; REDIRECT_ADDR = 16'h0100;
    #1;
    check("redir_ack_pc", {15'd0, C_PCWrite, PC_IN}, {15'd0, 1'b1, 16'h0100});
    step();
    IMEM_ACK = 1'b0; C_Redirect = 1'b0;
    check("redir_ack_no_valid", {31'd0, INSTR_VALID}, 32'd0);
    fetch_one(1, 16'h0100, 16'h0101, c0);

    // Redirect to the top of memory, then wrap
    do_reset(1'b0);
    step();
    C_Redirect = 1'b1; REDIRECT_ADDR = 16'hFFFF;
    #1;
    check("redir_idle_pc", {15'd0, C_PCWrite, PC_IN}, {15'd0, 1'b1, 16'hFFFF});
    step();
    C_Redirect = 1'b0; C_Enable = 1'b1;
    fetch_one(1, 16'hFFFF, 16'h7777, c0);
    fetch_one(1, 16'h0000, 16'h8888, c0);

    // Reset mid-fetch, then a late ack after release
    do_reset(1'b1);
    wait_req(c0);
    step();
    reset_n = 1'b0;
    #1;
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    check("midrst_outs", {29'd0, IMEM_REQ, INSTR_VALID, C_PCWrite}, 32'd1);
    check("midrst_pc_in", {16'd0, PC_IN}, 32'd0);
    step(); step();
    C_Enable = 1'b0;
    reset_n = 1'b1;
    IMEM_ACK = 1'b1; IMEM_DATA = 16'hBAD0;
    step();
    #1;
    check("late_ack_idle", {28'd0, dbg_state, C_PCWrite}, {28'd0, 3'd1, 1'b0});
    IMEM_ACK = 1'b0;
    step();
    check("late_ack_no_valid", {31'd0, INSTR_VALID}, 32'd0);
    check("late_ack_pc", {16'd0, pc_out}, 32'd0);
    C_Enable = 1'b1;
    fetch_one(1, 16'h0000, 16'h0F0F, c0);
    step(); step();

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 16'h0000, PC value loaded while reset is asserted and on the first clock after release.
REQ-002 Parameter PC_INC, 16'd1, sequential PC increment per fetched instruction.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 PC_OUT  in  16  current PC from the program counter register.
REQ-006 PC_IN  out  16  next PC value to the program counter register.
REQ-007 C_PCWrite  out  1  program counter load enable; PC_OUT takes PC_IN one edge later.
REQ-008 C_Enable  in  1  fetch enable.
REQ-009 C_Redirect  in  1  branch/jump redirect strobe, one cycle.
REQ-010 REDIRECT_ADDR  in  16  redirect target, valid with C_Redirect.
REQ-011 IMEM_REQ  out  1  instruction memory request, one-cycle pulse.
REQ-012 IMEM_ADDR  out  16  instruction memory address, valid with IMEM_REQ.
REQ-013 IMEM_ACK  in  1  instruction memory response strobe, any latency of 1 or more cycles after IMEM_REQ.
REQ-014 IMEM_DATA  in  16  instruction word, valid with IMEM_ACK.
REQ-015 INSTR  out  16  fetched instruction to decode.
REQ-016 INSTR_PC  out  16  address of INSTR.
REQ-017 INSTR_VALID  out  1  INSTR/INSTR_PC valid.
REQ-018 INSTR_READY  in  1  decode accepts; transfer when INSTR_VALID and INSTR_READY are both high.

Function
REQ-019 States SHALL be BOOT, IDLE, REQ, WAIT, FLUSH, VALID; at most one memory request SHALL be outstanding.
REQ-020 BOOT: PC_IN=RESET_VECTOR, C_PCWrite=1; the state advances to IDLE on the first edge after reset release.
REQ-021 IDLE: IMEM_REQ=0; if C_Enable=1, the next state is REQ.
REQ-022 REQ: IMEM_REQ=1 and IMEM_ADDR=PC_OUT for exactly one cycle; the next state is WAIT; IMEM_ACK is ignored in REQ.
REQ-023 WAIT on IMEM_ACK: capture INSTR=IMEM_DATA and INSTR_PC=IMEM_ADDR of that request, drive PC_IN=PC_OUT+PC_INC and C_PCWrite=1, and go to VALID.
REQ-024 PC arithmetic SHALL be modulo 2^16 (16'hFFFF+1 = 16'h0000); no carry-out.
REQ-025 VALID: INSTR_VALID=1; INSTR and INSTR_PC SHALL be stable until transfer; on transfer, go to REQ if C_Enable=1, else IDLE.
REQ-026 C_Enable=0 in REQ or WAIT SHALL NOT abort the fetch; it completes to VALID.
REQ-027 C_Redirect in any state except BOOT: PC_IN=REDIRECT_ADDR and C_PCWrite=1 that cycle; redirect overrides the increment.
REQ-028 Redirect in IDLE: go to REQ if C_Enable=1, else stay IDLE.
REQ-029 Redirect in REQ, or in WAIT without IMEM_ACK: go to FLUSH; FLUSH waits for IMEM_ACK, discards the data, then goes to REQ (C_Enable=1) or IDLE.
REQ-030 Redirect in WAIT with IMEM_ACK in the same cycle: discard the data, with no VALID, and go to REQ or IDLE per C_Enable.
REQ-031 Redirect in VALID: INSTR_VALID drops the next cycle; a same-cycle transfer counts as delivered; go to REQ or IDLE per C_Enable.
REQ-032 A redirect in FLUSH SHALL update the PC only; the state stays FLUSH.
REQ-033 C_PCWrite SHALL be 0 in every cycle not named in REQ-020, REQ-023 and REQ-027.

Reset
REQ-034 reset_n low SHALL immediately force state BOOT, IMEM_REQ=0, INSTR_VALID=0, INSTR=0, INSTR_PC=0, PC_IN=RESET_VECTOR and C_PCWrite=1.
REQ-035 Reset mid-fetch SHALL abandon the outstanding request; IMEM_ACK in BOOT or IDLE SHALL be ignored.

Verification
REQ-036 Reset, then C_Enable=1, with memory ACK 1 cycle after REQ and INSTR_READY=1 -> PC sequence 0,1,2,3; INSTR_PC matches; IMEM_REQ spaced by 3 cycles.
REQ-037 ACK latency of 4 cycles with INSTR_READY low for 5 cycles in VALID -> INSTR/INSTR_PC held; no new IMEM_REQ until transfer.
REQ-038 Redirect to 16'h0040 while in WAIT, with ACK 2 cycles later -> first ACK data is never valid; next IMEM_ADDR=16'h0040.
REQ-039 Redirect to 16'h0100 in the same cycle as IMEM_ACK -> PC_IN=16'h0100 (not PC+1); no INSTR_VALID; next fetch at 16'h0100.
REQ-040 Redirect to 16'hFFFF, then fetch -> next PC_IN=16'h0000.
REQ-041 reset_n low during WAIT, then a late ACK after release -> INSTR_VALID stays 0; PC=RESET_VECTOR; fetch restarts at 16'h0000.
